// File: rtl/vector_operand_fetch.sv
// Vector operand fetch stage: holds the VRF, splits LMUL>1 instructions into
// per-register micro-ops and presents one operand set per uop on a registered valid/ready port.
module vector_operand_fetch #(
  parameter int VRF_WIDTH         = 128,
  parameter int VRF_DEPTH         = 32,
  parameter int VRF_ADDRESS_WIDTH = $clog2(VRF_DEPTH),
  parameter int XRF_WIDTH         = 64
) (
  input  logic                         clk_i,
  input  logic                         rstn_i,
  input  logic                         issue_valid_i,
  output logic                         issue_ready_o,
  input  logic [VRF_ADDRESS_WIDTH-1:0] vs1_addr_i,
  input  logic [VRF_ADDRESS_WIDTH-1:0] vs2_addr_i,
  input  logic [VRF_ADDRESS_WIDTH-1:0] vd_addr_i,
  input  logic [1:0]                   vsew_i,
  input  logic [1:0]                   vlmul_i,
  input  logic [1:0]                   src_sel_i,
  input  logic                         imm_signed_i,
  input  logic [XRF_WIDTH-1:0]         rs1_i,
  input  logic                         flush_i,
  input  logic                         wb_valid_i,
  input  logic [VRF_ADDRESS_WIDTH-1:0] wb_addr_i,
  input  logic [VRF_WIDTH-1:0]         wb_data_i,
  output logic                         out_valid_o,
  input  logic                         out_ready_i,
  output logic [VRF_WIDTH-1:0]         out_vs1_o,
  output logic [VRF_WIDTH-1:0]         out_vs2_o,
  output logic [VRF_WIDTH-1:0]         out_vd_o,
  output logic [VRF_WIDTH-1:0]         out_vmask_o,
  output logic [2:0]                   out_uop_idx_o,
  output logic                         out_last_o
);

  localparam int VAW   = VRF_ADDRESS_WIDTH;
  localparam int NLANE = VRF_WIDTH / 8;

  typedef enum logic [1:0] {IDLE, SEQ, DRAIN} state_t;

  // Register index of uop k within a group, wrapping around the register file.
  function automatic logic [VAW-1:0] grp_addr(input logic [VAW-1:0] base, input logic [2:0] k);
    logic [VAW+3:0] sum;
    sum = (VAW+4)'(base) + (VAW+4)'(k);
    return VAW'(sum % (VAW+4)'(VRF_DEPTH));
  endfunction

  state_t               state_reg, state_next;
  logic [2:0]           cnt_reg;
  logic [VAW-1:0]       ctx_vs1_reg, ctx_vs2_reg, ctx_vd_reg;
  logic [2:0]           ctx_last_reg;
  logic                 ctx_vv_reg;
  logic [VRF_WIDTH-1:0] ctx_splat_reg;

  logic                 out_valid_reg;
  logic [VRF_WIDTH-1:0] out_vs1_reg, out_vs2_reg, out_vd_reg, out_vmask_reg;
  logic [2:0]           out_idx_reg;
  logic                 out_last_reg;

  logic [VRF_WIDTH-1:0] vrf_reg [VRF_DEPTH];

  logic accept, advance, load, stall;

  // ---------------- register file ----------------
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int i = 0; i < VRF_DEPTH; i++) vrf_reg[i] <= '0;
    end else if (wb_valid_i) begin
      vrf_reg[wb_addr_i] <= wb_data_i;
    end
  end

  // ---------------- issue-side decode ----------------
  logic [4:0]           imm5;
  logic [63:0]          imm_ext, splat_elem;
  logic [VRF_WIDTH-1:0] issue_splat;
  logic                 issue_vv;
  logic [2:0]           issue_last;

  assign imm5       = 5'(vs1_addr_i);
  assign imm_ext    = imm_signed_i ? {{59{imm5[4]}}, imm5} : {59'd0, imm5};
  assign splat_elem = (src_sel_i == 2'b01) ? rs1_i[63:0] : imm_ext;
  assign issue_vv   = !((src_sel_i == 2'b01) || (src_sel_i == 2'b10));

  // Each byte lane picks the byte of the element that lands on it for the current SEW.
  genvar gi;
  generate
    for (gi = 0; gi < NLANE; gi++) begin : g_splat
      assign issue_splat[gi*8 +: 8] =
        (vsew_i == 2'b00) ? splat_elem[7:0] :
        (vsew_i == 2'b01) ? splat_elem[(gi%2)*8 +: 8] :
        (vsew_i == 2'b10) ? splat_elem[(gi%4)*8 +: 8] :
                            splat_elem[(gi%8)*8 +: 8];
    end
  endgenerate

  always_comb begin
    issue_last = 3'd0;
    case (vlmul_i)
      2'b00: issue_last = 3'd0;
      2'b01: issue_last = 3'd1;
      2'b10: issue_last = 3'd3;
      2'b11: issue_last = 3'd7;
      default: issue_last = 3'd0;
    endcase
  end

  // ---------------- FSM ----------------
  always_comb begin
    state_next    = state_reg;
    accept        = 1'b0;
    advance       = 1'b0;
    issue_ready_o = 1'b0;
    case (state_reg)
      IDLE: begin
        issue_ready_o = 1'b1;
        accept        = issue_valid_i;
      end
      SEQ: begin
        if (out_ready_i) begin
          advance = 1'b1;
          if (cnt_reg == ctx_last_reg) state_next = DRAIN;
        end
      end
      DRAIN: begin
        issue_ready_o = out_ready_i;
        if (out_ready_i) begin
          if (issue_valid_i) accept = 1'b1;
          else               state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
    if (accept) state_next = (issue_last == 3'd0) ? DRAIN : SEQ;
    // Flush wins over everything, including an issue offered in the same cycle.
    if (flush_i) begin
      state_next    = IDLE;
      accept        = 1'b0;
      advance       = 1'b0;
      issue_ready_o = 1'b0;
    end
  end

  assign load  = accept || advance;
  assign stall = out_valid_reg && !out_ready_i;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_reg     <= IDLE;
      cnt_reg       <= 3'd0;
      ctx_vs1_reg   <= '0;
      ctx_vs2_reg   <= '0;
      ctx_vd_reg    <= '0;
      ctx_last_reg  <= 3'd0;
      ctx_vv_reg    <= 1'b0;
      ctx_splat_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        cnt_reg       <= 3'd1;
        ctx_vs1_reg   <= vs1_addr_i;
        ctx_vs2_reg   <= vs2_addr_i;
        ctx_vd_reg    <= vd_addr_i;
        ctx_last_reg  <= issue_last;
        ctx_vv_reg    <= issue_vv;
        ctx_splat_reg <= issue_splat;
      end else if (advance) begin
        cnt_reg <= cnt_reg + 3'd1;
      end else if (state_next == IDLE) begin
        cnt_reg <= 3'd0;
      end
    end
  end

  // ---------------- uop operand read (write-through) ----------------
  logic [VAW-1:0]       ld_vs1_base, ld_vs2_base, ld_vd_base;
  logic [2:0]           ld_idx, ld_last;
  logic                 ld_vv;
  logic [VRF_WIDTH-1:0] ld_splat;
  logic [VAW-1:0]       rd_addr [4];
  logic [VRF_WIDTH-1:0] rd_data [4];

  always_comb begin
    ld_vs1_base = accept ? vs1_addr_i  : ctx_vs1_reg;
    ld_vs2_base = accept ? vs2_addr_i  : ctx_vs2_reg;
    ld_vd_base  = accept ? vd_addr_i   : ctx_vd_reg;
    ld_idx      = accept ? 3'd0        : cnt_reg;
    ld_last     = accept ? issue_last  : ctx_last_reg;
    ld_vv       = accept ? issue_vv    : ctx_vv_reg;
    ld_splat    = accept ? issue_splat : ctx_splat_reg;
    rd_addr[0]  = grp_addr(ld_vs1_base, ld_idx);
    rd_addr[1]  = grp_addr(ld_vs2_base, ld_idx);
    rd_addr[2]  = grp_addr(ld_vd_base,  ld_idx);
    rd_addr[3]  = '0;
  end

  generate
    for (gi = 0; gi < 4; gi++) begin : g_rd
      assign rd_data[gi] = (wb_valid_i && (wb_addr_i == rd_addr[gi])) ? wb_data_i : vrf_reg[rd_addr[gi]];
    end
  endgenerate

  // ---------------- output register with stall snoop ----------------
  logic [VAW-1:0] hold_vs1_addr, hold_vs2_addr, hold_vd_addr;

  assign hold_vs1_addr = grp_addr(ctx_vs1_reg, out_idx_reg);
  assign hold_vs2_addr = grp_addr(ctx_vs2_reg, out_idx_reg);
  assign hold_vd_addr  = grp_addr(ctx_vd_reg,  out_idx_reg);

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      out_valid_reg <= 1'b0;
      out_vs1_reg   <= '0;
      out_vs2_reg   <= '0;
      out_vd_reg    <= '0;
      out_vmask_reg <= '0;
      out_idx_reg   <= 3'd0;
      out_last_reg  <= 1'b0;
    end else begin
      out_valid_reg <= (state_next != IDLE);
      if (load) begin
        out_vs1_reg   <= ld_vv ? rd_data[0] : ld_splat;
        out_vs2_reg   <= rd_data[1];
        out_vd_reg    <= rd_data[2];
        out_vmask_reg <= rd_data[3];
        out_idx_reg   <= ld_idx;
        out_last_reg  <= (ld_idx == ld_last);
      end else if (stall && wb_valid_i) begin
        // A splatted vs1 has no register behind it, so only vv vs1 is refreshed.
        if (ctx_vv_reg && (wb_addr_i == hold_vs1_addr)) out_vs1_reg <= wb_data_i;
        if (wb_addr_i == hold_vs2_addr) out_vs2_reg   <= wb_data_i;
        if (wb_addr_i == hold_vd_addr)  out_vd_reg    <= wb_data_i;
        if (wb_addr_i == '0)            out_vmask_reg <= wb_data_i;
      end
    end
  end

  assign out_valid_o   = out_valid_reg;
  assign out_vs1_o     = out_vs1_reg;
  assign out_vs2_o     = out_vs2_reg;
  assign out_vd_o      = out_vd_reg;
  assign out_vmask_o   = out_vmask_reg;
  assign out_uop_idx_o = out_idx_reg;
  assign out_last_o    = out_last_reg;

endmodule
